param_tap: RTL and testbench

// Parametrised IEEE 1149.1-style TAP: 16-state controller, IR, BYPASS/IDCODE regs, and an
//  N_PI+N_PO boundary-scan register. Drives an external core scan chain. Sits between chip

---
 rtl/param_tap.sv | 157 +++++++++++++++
 tb/tb_param_tap.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_tap.sv
// param_tap: parametrised 1149.1 TAP controller with IR, BYPASS, IDCODE,
// boundary-scan register and a hook for an external core scan chain.
// Ports: CK/TRST/TMS/TDI -> TDO/tdo_en (JTAG pins);
//   chip_pi/core_pi, core_po/chip_po (boundary cells);
//   scan_si/scan_so/scan_se/scan_capt (core chain); test_mode.
module param_tap #(
  parameter int          N_PI   = 2,
  parameter int          N_PO   = 2,
  parameter int          IR_W   = 3,
  parameter logic [31:0] IDCODE = 32'h1000_0001
) (
  input  logic            CK,
  input  logic            TRST,
  input  logic            TMS,
  input  logic            TDI,
  output logic            TDO,
  output logic            tdo_en,
  input  logic [N_PI-1:0] chip_pi,
  output logic [N_PI-1:0] core_pi,
  input  logic [N_PO-1:0] core_po,
  output logic [N_PO-1:0] chip_po,
  output logic            scan_si,
  input  logic            scan_so,
  output logic            scan_se,
  output logic            scan_capt,
  output logic            test_mode
);

  localparam int L = N_PI + N_PO;

  localparam logic [IR_W-1:0] OP_EXTEST = IR_W'(3'b000);
  localparam logic [IR_W-1:0] OP_SAMPLE = IR_W'(3'b001);
  localparam logic [IR_W-1:0] OP_INTEST = IR_W'(3'b010);
  localparam logic [IR_W-1:0] OP_SCAN   = IR_W'(3'b011);
  localparam logic [IR_W-1:0] OP_IDCODE = IR_W'(3'b110);

  typedef enum logic [3:0] {
    TLR, RTI,
    SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
  } state_t;

  state_t          state_q, state_d;
  logic [IR_W-1:0] ir_q, ir_d;
  logic [IR_W-1:0] ir_sr_q, ir_sr_d;
  logic [L-1:0]    bsr_q, bsr_d;
  logic [L-1:0]    upd_q, upd_d;
  logic            byp_q, byp_d;
  logic [31:0]     id_q, id_d;

  logic is_ext, is_smp, is_int, is_scn, is_idc;
  logic is_bsr, is_byp;

  assign is_ext = (ir_q == OP_EXTEST);
  assign is_smp = (ir_q == OP_SAMPLE);
  assign is_int = (ir_q == OP_INTEST);
  assign is_scn = (ir_q == OP_SCAN);
  assign is_idc = (ir_q == OP_IDCODE);
  assign is_bsr = is_ext | is_smp | is_int;
  // Unassigned opcodes fall through to BYPASS.
  assign is_byp = ~(is_bsr | is_scn | is_idc);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TLR:     state_d = TMS ? TLR    : RTI;
      RTI:     state_d = TMS ? SEL_DR : RTI;
      SEL_DR:  state_d = TMS ? SEL_IR : CAP_DR;
      CAP_DR:  state_d = TMS ? EX1_DR : SH_DR;
      SH_DR:   state_d = TMS ? EX1_DR : SH_DR;
      EX1_DR:  state_d = TMS ? UPD_DR : PAU_DR;
      PAU_DR:  state_d = TMS ? EX2_DR : PAU_DR;
      EX2_DR:  state_d = TMS ? UPD_DR : SH_DR;
      UPD_DR:  state_d = TMS ? SEL_DR : RTI;
      SEL_IR:  state_d = TMS ? TLR    : CAP_IR;
      CAP_IR:  state_d = TMS ? EX1_IR : SH_IR;
      SH_IR:   state_d = TMS ? EX1_IR : SH_IR;
      EX1_IR:  state_d = TMS ? UPD_IR : PAU_IR;
      PAU_IR:  state_d = TMS ? EX2_IR : PAU_IR;
      EX2_IR:  state_d = TMS ? UPD_IR : SH_IR;
      UPD_IR:  state_d = TMS ? SEL_DR : RTI;
      default: state_d = TLR;
    endcase
  end

  always_comb begin
    ir_sr_d = ir_sr_q;
    ir_d    = ir_q;
    bsr_d   = bsr_q;
    upd_d   = upd_q;
    byp_d   = byp_q;
    id_d    = id_q;

    if (state_q == CAP_IR) ir_sr_d = IR_W'(1);
    if (state_q == SH_IR)  ir_sr_d = {TDI, ir_sr_q[IR_W-1:1]};
    if (state_q == UPD_IR) ir_d    = ir_sr_q;
    // Entering TLR forces IDCODE so the op is already valid in TLR.
    if (state_d == TLR)    ir_d    = OP_IDCODE;

    if (is_bsr) begin
      if (state_q == CAP_DR) bsr_d = {chip_pi, core_po};
      if (state_q == SH_DR)  bsr_d = {TDI, bsr_q[L-1:1]};
      if (state_q == UPD_DR) upd_d = bsr_q;
    end
    if (is_byp) begin
      if (state_q == CAP_DR) byp_d = 1'b0;
      if (state_q == SH_DR)  byp_d = TDI;
    end
    if (is_idc) begin
      if (state_q == CAP_DR) id_d = IDCODE;
      if (state_q == SH_DR)  id_d = {TDI, id_q[31:1]};
    end
  end

  always_ff @(posedge CK) begin
    if (TRST) begin
      state_q <= TLR;
      ir_q    <= OP_IDCODE;
      ir_sr_q <= '0;
      bsr_q   <= '0;
      upd_q   <= '0;
      byp_q   <= 1'b0;
      id_q    <= IDCODE;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      ir_sr_q <= ir_sr_d;
      bsr_q   <= bsr_d;
      upd_q   <= upd_d;
      byp_q   <= byp_d;
      id_q    <= id_d;
    end
  end

  assign tdo_en    = (state_q == SH_DR) | (state_q == SH_IR);
  assign scan_si   = TDI;
  assign scan_se   = is_scn & (state_q == SH_DR);
  assign scan_capt = is_scn & (state_q == CAP_DR);
  assign test_mode = is_ext | is_int | is_scn;
  assign chip_po   = is_ext ? upd_q[N_PO-1:0] : core_po;
  assign core_pi   = is_int ? upd_q[L-1:N_PO] : chip_pi;

  always_comb begin
    TDO = 1'b0;
    if (state_q == SH_IR) begin
      TDO = ir_sr_q[0];
    end else if (state_q == SH_DR) begin
      unique case (1'b1)
        is_bsr:  TDO = bsr_q[0];
        is_scn:  TDO = scan_so;
        is_idc:  TDO = id_q[0];
        default: TDO = byp_q;
      endcase
    end
  end

endmodule

// File: tb/tb_param_tap.sv
// tb_param_tap: random + directed bench for param_tap with a
// table-driven TAP model and an external 3-bit core chain.
module tb_param_tap;

  localparam logic [31:0] IDC = 32'h1000_0001;
  localparam int S_TLR = 0, S_CDR = 3, S_SHDR = 4, S_UDR = 8;
  localparam int S_CIR = 10, S_SHIR = 11, S_UIR = 15;

  logic CK = 1'b0;
  logic TRST, TMS, TDI, TDO, tdo_en;
  logic scan_si, scan_so, scan_se, scan_capt, test_mode;
  logic [1:0] chip_pi, core_pi, core_po, chip_po;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  int nx0[16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  int nx1[16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};

  int          m_st = 0;
  int          m_ir = 6;
  logic [2:0]  m_irsr = '0;
  logic [3:0]  m_bsr = '0;
  logic [3:0]  m_upd = '0;
  logic        m_byp = 1'b0;
  logic [31:0] m_id = '0;
  logic [2:0]  chain = '0;
  logic [2:0]  cap_val = 3'b101;

  logic got_tdo, got_en;
  int   cnt_se, cnt_capt;
  logic [63:0] d, en;
  int   n;

  param_tap #(
    .N_PI(2), .N_PO(2), .IR_W(3), .IDCODE(IDC)
  ) dut (
    .CK(CK), .TRST(TRST), .TMS(TMS), .TDI(TDI),
    .TDO(TDO), .tdo_en(tdo_en),
    .chip_pi(chip_pi), .core_pi(core_pi),
    .core_po(core_po), .chip_po(chip_po),
    .scan_si(scan_si), .scan_so(scan_so),
    .scan_se(scan_se), .scan_capt(scan_capt),
    .test_mode(test_mode)
  );

  assign scan_so = chain[0];

  always #5 CK = ~CK;

  function automatic int kind(int ir);
    if (ir inside {0, 1, 2, 3, 6}) return ir;
    return 7;
  endfunction

  function automatic logic [9:0] expect_out();
    int   k;
    logic e_tdo, sh_dr, sh_ir;
    logic [1:0] e_po, e_pi;
    k = kind(m_ir);
    sh_dr = (m_st == S_SHDR);
    sh_ir = (m_st == S_SHIR);
    e_tdo = 1'b0;
    if (sh_ir) e_tdo = m_irsr[0];
    else if (sh_dr) begin
      case (k)
        0, 1, 2: e_tdo = m_bsr[0];
        3:       e_tdo = chain[0];
        6:       e_tdo = m_id[0];
        default: e_tdo = m_byp;
      endcase
    end
    e_po = (k == 0) ? m_upd[1:0] : core_po;
    e_pi = (k == 2) ? m_upd[3:2] : chip_pi;
    return {e_tdo, (sh_dr | sh_ir), e_po, e_pi,
            ((k == 3) & sh_dr), ((k == 3) & (m_st == S_CDR)),
            ((k == 0) | (k == 2) | (k == 3)), TDI};
  endfunction

  always @(negedge CK) begin
    logic [9:0] e, a;
    if (chk_on) begin
      e = expect_out();
      a = {TDO, tdo_en, chip_po, core_pi,
           scan_se, scan_capt, test_mode, scan_si};
      n_cmp++;
      if (a !== e) begin
        n_err++;
        $display("FAIL cycle t=%0t st=%0d ir=%0d got=%b want=%b",
                 $time, m_st, m_ir, a, e);
      end
    end
  end

  task automatic model_step();
    int k;
    k = kind(m_ir);
    if (k == 3 && m_st == S_CDR) chain = cap_val;
    else if (k == 3 && m_st == S_SHDR) chain = {TDI, chain[2:1]};
    if (TRST) begin
      m_st = S_TLR; m_ir = 6; m_irsr = '0;
      m_bsr = '0; m_upd = '0; m_byp = 1'b0;
    end else begin
      case (m_st)
        S_CIR:  m_irsr = 3'b001;
        S_SHIR: m_irsr = {TDI, m_irsr[2:1]};
        S_UIR:  m_ir = int'(m_irsr);
        S_CDR: begin
          if (k < 3) m_bsr = {chip_pi, core_po};
          else if (k == 6) m_id = IDC;
          else if (k == 7) m_byp = 1'b0;
        end
        S_SHDR: begin
          if (k < 3) m_bsr = {TDI, m_bsr[3:1]};
          else if (k == 6) m_id = {TDI, m_id[31:1]};
          else if (k == 7) m_byp = TDI;
        end
        S_UDR: if (k < 3) m_upd = m_bsr;
        default: ;
      endcase
      m_st = TMS ? nx1[m_st] : nx0[m_st];
      if (m_st == S_TLR) m_ir = 6;
    end
  endtask

  task automatic chk(string nm, logic [63:0] a, logic [63:0] e);
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s got=%h want=%h", nm, a, e);
    end
  endtask

  task automatic cyc(logic tms, logic tdi);
    TMS = tms;
    TDI = tdi;
    @(negedge CK);
    got_tdo = TDO;
    got_en  = tdo_en;
    cnt_se   += int'(scan_se);
    cnt_capt += int'(scan_capt);
    @(posedge CK);
    model_step();
    #1;
  endtask

  task automatic to_rti();
    repeat (5) cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
  endtask

  task automatic load_ir(logic [2:0] op);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, op[0]);
    cyc(1'b0, op[1]);
    cyc(1'b1, op[2]);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
  endtask

  task automatic shift_dr(int nb, logic [63:0] din,
                          output logic [63:0] dout,
                          output logic [63:0] den);
    dout = '0;
    den  = '0;
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    for (int i = 0; i < nb; i++) begin
      cyc(i == nb - 1, din[i]);
      dout[i] = got_tdo;
      den[i]  = got_en;
    end
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
  endtask

  initial begin
    TRST = 1'b1; TMS = 1'b0; TDI = 1'b0;
    chip_pi = 2'b01; core_po = 2'b11;
    cnt_se = 0; cnt_capt = 0;
    cyc(1'b0, 1'b0);
    TRST = 1'b0;
    chk_on = 1'b1;
    chk("rst_tdo_en", 64'(tdo_en), 64'd0);
    chk("rst_test_mode", 64'(test_mode), 64'd0);
    chk("rst_chip_po", 64'(chip_po), 64'b11);
    chk("rst_core_pi", 64'(core_pi), 64'b01);

    cyc(1'b0, 1'b0);
    shift_dr(32, 64'd0, d, en);
    chk("idcode", 64'(d[31:0]), 64'h1000_0001);
    chk("idcode_en", 64'(en[31:0]), 64'hFFFF_FFFF);
    chk("rti_en", 64'(tdo_en), 64'd0);

    load_ir(3'b111);
    shift_dr(5, 64'b01101, d, en);
    chk("bypass_111", 64'(d[4:0]), 64'b11010);
    load_ir(3'b100);
    shift_dr(5, 64'b01101, d, en);
    chk("bypass_100", 64'(d[4:0]), 64'b11010);

    chip_pi = 2'b10; core_po = 2'b01;
    load_ir(3'b000);
    shift_dr(4, 64'b1100, d, en);
    chk("extest_cap", 64'(d[3:0]), 64'b1001);
    chk("extest_po", 64'(chip_po), 64'b00);
    chk("extest_tm", 64'(test_mode), 64'd1);
    shift_dr(4, 64'b0011, d, en);
    chk("extest_po2", 64'(chip_po), 64'b11);

    chip_pi = 2'b00;
    load_ir(3'b010);
    shift_dr(4, 64'b1100, d, en);
    chk("intest_pi", 64'(core_pi), 64'b11);
    chk("intest_po", 64'(chip_po), 64'b01);
    load_ir(3'b001);
    chk("sample_pi", 64'(core_pi), 64'b00);
    chk("sample_tm", 64'(test_mode), 64'd0);

    cap_val = 3'b101;
    load_ir(3'b011);
    cnt_se = 0; cnt_capt = 0;
    shift_dr(3, 64'b110, d, en);
    chk("scan_tdo", 64'(d[2:0]), 64'b101);
    chk("scan_se_cnt", 64'(cnt_se), 64'd3);
    chk("scan_capt_cnt", 64'(cnt_capt), 64'd1);

    core_po = 2'b10;
    load_ir(3'b000);
    shift_dr(4, 64'b0011, d, en);
    chk("midop_pre", 64'(chip_po), 64'b11);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    TRST = 1'b1;
    cyc(1'b0, 1'b1);
    TRST = 1'b0;
    chk("midop_po", 64'(chip_po), 64'b10);
    chk("midop_tm", 64'(test_mode), 64'd0);
    cyc(1'b0, 1'b0);
    shift_dr(32, 64'd0, d, en);
    chk("midop_idcode", 64'(d[31:0]), 64'h1000_0001);
    load_ir(3'b000);
    chk("midop_upd", 64'(chip_po), 64'b00);
    repeat (5) cyc(1'b1, 1'b0);
    chk("tms5_tm", 64'(test_mode), 64'd0);
    chk("tms5_po", 64'(chip_po), 64'b10);

    for (int it = 0; it < 90; it++) begin
      chip_pi = 2'($urandom);
      core_po = 2'($urandom);
      cap_val = 3'($urandom);
      case ($urandom_range(0, 2))
        0: begin
          to_rti();
          load_ir(3'($urandom));
          repeat (3) begin
            n = $urandom_range(1, 12);
            shift_dr(n, {$urandom, $urandom}, d, en);
            chip_pi = 2'($urandom);
            core_po = 2'($urandom);
          end
        end
        1: begin
          repeat (25) begin
            TRST = ($urandom_range(0, 63) == 0);
            chip_pi = 2'($urandom);
            core_po = 2'($urandom);
            cyc(1'($urandom), 1'($urandom));
          end
          TRST = 1'b0;
        end
        default: begin
          to_rti();
          load_ir(3'($urandom));
          repeat (30) begin
            core_po = 2'($urandom);
            cyc(1'($urandom), 1'($urandom));
          end
        end
      endcase
    end

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
